uart_rx_fifo: RTL and testbench

Parametrised UART receiver with an integrated receive FIFO. It replaces the fixed 8-bit, single-baud receive path feeding the keyboard/serial input buffer. Serial frames arrive on `rs_rx` and are synchronised, sampled at mid-bit and checked for framing. Valid words are pushed into a show-ahead FIFO that the consumer pops with `rd_en`.

---
 rtl/uart_rx_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (start / DATA_BITS LSB-first / optional parity / stop) feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to compile in the parity bit, the PARITY_ODD parameter and parity_err.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 32
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rs_rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          rx_done,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int NW           = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;
    logic                 pend_wr;
    logic                 pend_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 pend_perr;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [NW-1:0]        count;
    logic                 full;
    logic                 do_rd;
    logic                 do_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rs_rx;
            rx_s  <= sync1;
        end
    end

    // Each bit is sampled when the down-counter reaches zero; pend_* carry the stop-bit verdict for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            pend_wr   <= 1'b0;
            pend_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pend_perr <= 1'b0;
            par_bad   <= 1'b0;
`endif
        end else begin
            pend_wr   <= 1'b0;
            pend_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pend_perr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= CW'(HALF_BIT - 1);
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        state   <= DATA;
                        cnt     <= CW'(CLKS_PER_BIT - 1);
                        bit_cnt <= BW'(DATA_BITS - 1);
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        if (bit_cnt == '0) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_bad <= ((^shift) ^ rx_s) != PARITY_ODD;
                        state   <= STOP;
                        cnt     <= CW'(CLKS_PER_BIT - 1);
                    end
                end
`endif
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        pend_ferr <= 1'b1;
                        state     <= BREAK;
                    end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                        pend_perr <= 1'b1;
`endif
                        state     <= IDLE;
                    end else begin
                        pend_wr <= 1'b1;
                        state   <= IDLE;
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_bad = 1'b0;
`endif

    assign full     = (count == NW'(FIFO_DEPTH));
    assign do_rd    = rd_en && (count != '0);
    // A full FIFO still accepts a word when the head is popped in the same cycle.
    assign do_wr    = pend_wr && (!full || do_rd);
    assign rx_valid = (count != '0);
    assign rx_count = count;
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && do_wr) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_done     <= 1'b0;
            overrun_err <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rx_done     <= do_wr;
            overrun_err <= pend_wr && !do_wr;
            frame_err   <= pend_ferr;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= pend_perr;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: 16 clocks per bit, 8 data bits, 4-entry FIFO, queue reference model.
module tb_uart_rx_fifo;
    localparam int CPB = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_OFS = 171;
`else
    localparam int STOP_OFS = 155;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs_rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_done, frame_err, overrun_err, parity_err;
    logic [2:0] rx_count;

    int errors = 0;
    int checks = 0;
    int n_done = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    logic [7:0] model_q[$];

    uart_rx_fifo #(
        .CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rs_rx(rs_rx), .rd_en(rd_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_done(rx_done),
        .rx_count(rx_count), .frame_err(frame_err),
        .overrun_err(overrun_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done)     n_done++;
        if (frame_err)   n_ferr++;
        if (overrun_err) n_ovr++;
        if (parity_err)  n_perr++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the test list");
        $fatal(1);
    end

    // Serial frame driven on negedges; a low stop bit leaves the line low afterwards.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        @(negedge clk);
        rs_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rs_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rs_rx = (^d) ^ bad_par;
        repeat (CPB) @(negedge clk);
`else
        if (bad_par) rs_rx = 1'b1;
`endif
        rs_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        if (stop_bit) begin
            rs_rx = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic model_push(input logic [7:0] d, inout int exp_ovr);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else exp_ovr++;
    endtask

    task automatic pop;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rs_rx = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_valid, rx_done, frame_err, overrun_err, parity_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {rx_valid, rx_done, frame_err, overrun_err, parity_err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rx_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rx_count); end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", rx_data); end
        model_q.delete();
    endtask

    task automatic test_single;
        int d0 = n_done;
        send_frame(8'hA5, 1'b1, 1'b0);
        checks++;
        if (n_done - d0 !== 1) begin errors++; $display("FAIL single_done: got %0d pulses expected 1", n_done - d0); end
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rx_valid); end
        checks++;
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h expected a5", rx_data); end
        checks++;
        if (rx_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", rx_count); end
        pop();
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", rx_valid); end
        pop();
        checks++;
        if (rx_count !== 3'd0) begin errors++; $display("FAIL empty_read_count: got %0d expected 0", rx_count); end
    endtask

    task automatic test_glitch;
        int d0 = n_done;
        int e0 = n_ferr + n_ovr + n_perr;
        logic [7:0] d = 8'($urandom_range(0, 255));
        @(negedge clk);
        rs_rx = 1'b0;
        repeat (4) @(negedge clk);
        rs_rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if ((n_done - d0) !== 0 || (n_ferr + n_ovr + n_perr - e0) !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got done=%0d err=%0d expected 0 0", n_done - d0, n_ferr + n_ovr + n_perr - e0);
        end
        send_frame(d, 1'b1, 1'b0);
        checks++;
        if (rx_data !== d || rx_count !== 3'd1) begin
            errors++;
            $display("FAIL glitch_recover: got %02h/%0d expected %02h/1", rx_data, rx_count, d);
        end
        pop();
    endtask

    task automatic test_break;
        int f0 = n_ferr;
        int d0 = n_done;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        checks++;
        if (n_ferr - f0 !== 1) begin errors++; $display("FAIL break_ferr: got %0d pulses expected 1", n_ferr - f0); end
        checks++;
        if ((n_done - d0) !== 0 || rx_count !== 3'd0) begin
            errors++;
            $display("FAIL break_discard: got done=%0d count=%0d expected 0 0", n_done - d0, rx_count);
        end
        rs_rx = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h55, 1'b1, 1'b0);
        checks++;
        if (rx_data !== 8'h55 || n_ferr - f0 !== 1) begin
            errors++;
            $display("FAIL break_recover: got %02h ferr=%0d expected 55 ferr=1", rx_data, n_ferr - f0);
        end
        pop();
    endtask

    task automatic test_overrun;
        int o0 = n_ovr;
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b0);
        checks++;
        if (n_ovr - o0 !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", n_ovr - o0); end
        checks++;
        if (rx_count !== 3'd4) begin errors++; $display("FAIL overrun_count: got %0d expected 4", rx_count); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rx_data !== 8'(i)) begin errors++; $display("FAIL overrun_order: got %02h expected %02h", rx_data, 8'(i)); end
            pop();
        end
        checks++;
        if (rx_count !== 3'd0) begin errors++; $display("FAIL overrun_drain: got %0d expected 0", rx_count); end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, 1'b0);
            checks++;
            if (rx_data !== d) begin errors++; $display("FAIL wrap_data: got %02h expected %02h", rx_data, d); end
            pop();
        end
    endtask

    task automatic test_full_read;
        int o0 = n_ovr;
        int d0 = n_done;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, 1'b0);
            model_q.push_back(d);
        end
        fork
            send_frame(8'h05, 1'b1, 1'b0);
            begin
                @(negedge clk);
                repeat (STOP_OFS) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        void'(model_q.pop_front());
        model_q.push_back(8'h05);
        checks++;
        if (n_ovr - o0 !== 0 || n_done - d0 !== DEPTH + 1) begin
            errors++;
            $display("FAIL fullread_flags: got ovr=%0d done=%0d expected 0 %0d", n_ovr - o0, n_done - d0, DEPTH + 1);
        end
        checks++;
        if (rx_count !== 3'd4) begin errors++; $display("FAIL fullread_count: got %0d expected 4", rx_count); end
        while (model_q.size() > 0) begin
            checks++;
            if (rx_data !== model_q[0]) begin errors++; $display("FAIL fullread_data: got %02h expected %02h", rx_data, model_q[0]); end
            void'(model_q.pop_front());
            pop();
        end
    endtask

    task automatic test_random;
        int o0 = n_ovr;
        int exp_ovr = 0;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d = 8'($urandom_range(0, 255));
            int reads = $urandom_range(0, 2);
            send_frame(d, 1'b1, 1'b0);
            model_push(d, exp_ovr);
            checks++;
            if (rx_count !== 3'(model_q.size())) begin
                errors++;
                $display("FAIL random_count: got %0d expected %0d", rx_count, model_q.size());
            end
            for (int r = 0; r < reads && model_q.size() > 0; r++) begin
                checks++;
                if (rx_data !== model_q[0]) begin errors++; $display("FAIL random_data: got %02h expected %02h", rx_data, model_q[0]); end
                void'(model_q.pop_front());
                pop();
            end
        end
        checks++;
        if (n_ovr - o0 !== exp_ovr) begin errors++; $display("FAIL random_overrun: got %0d expected %0d", n_ovr - o0, exp_ovr); end
        while (model_q.size() > 0) begin
            void'(model_q.pop_front());
            pop();
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d = 8'($urandom_range(0, 255));
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        @(negedge clk);
        rs_rx = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rs_rx = 1'b1;
        checks++;
        if ({rx_valid, rx_done, frame_err, overrun_err, parity_err} !== 5'b0 || rx_count !== 3'd0 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got flags=%b count=%0d data=%02h expected 00000 0 00",
                     {rx_valid, rx_done, frame_err, overrun_err, parity_err}, rx_count, rx_data);
        end
        rst = 1'b0;
        model_q.delete();
        repeat (20) @(negedge clk);
        send_frame(d, 1'b1, 1'b0);
        checks++;
        if (rx_data !== d || rx_count !== 3'd1) begin
            errors++;
            $display("FAIL midreset_recover: got %02h/%0d expected %02h/1", rx_data, rx_count, d);
        end
        pop();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int p0 = n_perr;
        int d0 = n_done;
        send_frame(8'h07, 1'b1, 1'b1);
        checks++;
        if (n_perr - p0 !== 1) begin errors++; $display("FAIL parity_pulse: got %0d expected 1", n_perr - p0); end
        checks++;
        if (n_done - d0 !== 0 || rx_count !== 3'd0) begin
            errors++;
            $display("FAIL parity_discard: got done=%0d count=%0d expected 0 0", n_done - d0, rx_count);
        end
        send_frame(8'h07, 1'b1, 1'b0);
        checks++;
        if (rx_data !== 8'h07 || n_perr - p0 !== 1) begin
            errors++;
            $display("FAIL parity_good: got %02h perr=%0d expected 07 perr=1", rx_data, n_perr - p0);
        end
        pop();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_break();
        test_overrun();
        test_full_read();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
